// File: rtl/tv80_blkseq.sv
// Block-transfer sequencer (LDI/LDD/LDIR/LDDR): memory read, memory write, then HL/DE/BC rewrites.
// 6 cycles start-to-done, 5 per repeat; mem_ack low or cen low stalls in place.
module tv80_blkseq (
    input  logic        clk,
    input  logic        reset,
    input  logic        cen,
    input  logic        start,
    input  logic        op_dec,
    input  logic        op_rpt,
    input  logic        irq_pend,
    output logic        busy,
    output logic        done,
    output logic        rpt_abort,
    output logic        pv_flag,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    input  logic        mem_ack,
    output logic [2:0]  rf_addr_a,
    output logic [2:0]  rf_addr_b,
    output logic [2:0]  rf_addr_c,
    input  logic [7:0]  rf_doah,
    input  logic [7:0]  rf_doal,
    input  logic [7:0]  rf_dobh,
    input  logic [7:0]  rf_dobl,
    input  logic [7:0]  rf_doch,
    input  logic [7:0]  rf_docl,
    output logic [7:0]  rf_dih,
    output logic [7:0]  rf_dil,
    output logic        rf_weh,
    output logic        rf_wel
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR     = 3'd2,
        S_UPD_HL = 3'd3,
        S_UPD_DE = 3'd4,
        S_UPD_BC = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic        dec_q, dec_d;
    logic        rpt_q, rpt_d;
    logic        abort_q, abort_d;
    logic        pv_q, pv_d;
    logic [7:0]  byte_q, byte_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        we_q, we_d;
    logic [2:0]  addr_a_q, addr_a_d;

    logic [15:0] pair_a;
    logic [15:0] pair_step;
    logic [15:0] bc_dec;
    logic [15:0] wdata;

    assign pair_a    = {rf_doah, rf_doal};
    assign pair_step = dec_q ? (pair_a - 16'd1) : (pair_a + 16'd1);
    assign bc_dec    = pair_a - 16'd1;

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        rpt_d   = rpt_q;
        abort_d = abort_q;
        pv_d    = pv_q;
        byte_d  = byte_q;
        if (cen) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dec_d   = op_dec;
                        rpt_d   = op_rpt;
                        abort_d = 1'b0;
                        state_d = S_RD;
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        byte_d  = mem_din;
                        state_d = S_WR;
                    end
                end
                S_WR: begin
                    if (mem_ack) begin
                        state_d = S_UPD_HL;
                    end
                end
                S_UPD_HL: state_d = S_UPD_DE;
                S_UPD_DE: state_d = S_UPD_BC;
                S_UPD_BC: begin
                    pv_d = (bc_dec != 16'd0);
                    // An interrupt only suspends a repeat that still has work left.
                    if (rpt_q && (bc_dec != 16'd0) && !irq_pend) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_DONE;
                        abort_d = rpt_q && (bc_dec != 16'd0);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    abort_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Control outputs are registered decodes of the state being entered.
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        rd_d     = (state_d == S_RD);
        wr_d     = (state_d == S_WR);
        we_d     = (state_d == S_UPD_HL) || (state_d == S_UPD_DE) || (state_d == S_UPD_BC);
        addr_a_d = 3'd0;
        if (state_d == S_UPD_HL) begin
            addr_a_d = 3'd2;
        end else if (state_d == S_UPD_DE) begin
            addr_a_d = 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dec_q    <= 1'b0;
            rpt_q    <= 1'b0;
            abort_q  <= 1'b0;
            pv_q     <= 1'b0;
            byte_q   <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_a_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            dec_q    <= dec_d;
            rpt_q    <= rpt_d;
            abort_q  <= abort_d;
            pv_q     <= pv_d;
            byte_q   <= byte_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            we_q     <= we_d;
            addr_a_q <= addr_a_d;
        end
    end

    always_comb begin
        mem_addr = 16'd0;
        wdata    = 16'd0;
        case (state_q)
            S_RD:     mem_addr = {rf_dobh, rf_dobl};
            S_WR:     mem_addr = {rf_doch, rf_docl};
            S_UPD_HL: wdata    = pair_step;
            S_UPD_DE: wdata    = pair_step;
            S_UPD_BC: wdata    = bc_dec;
            default: begin
                mem_addr = 16'd0;
                wdata    = 16'd0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rpt_abort = abort_q;
    assign pv_flag   = pv_q;
    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;
    assign mem_dout  = byte_q;
    assign rf_addr_a = addr_a_q;
    assign rf_addr_b = 3'd2;
    assign rf_addr_c = 3'd1;
    assign rf_dih    = wdata[15:8];
    assign rf_dil    = wdata[7:0];
    // The register file has no reset, so a write in flight must not land on a reset edge.
    assign rf_weh    = we_q & ~reset;
    assign rf_wel    = we_q & ~reset;

endmodule

// File: tb/tb_tv80_blkseq.sv
// Bench for tv80_blkseq: register file and memory models around the DUT, block-copy reference model.
module tb_tv80_blkseq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cen, start, op_dec, op_rpt, irq_pend;
    logic        busy, done, rpt_abort, pv_flag;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr, mem_ack;
    logic [7:0]  mem_dout, mem_din;
    logic [2:0]  rf_addr_a, rf_addr_b, rf_addr_c;
    logic [7:0]  rf_doah, rf_doal, rf_dobh, rf_dobl, rf_doch, rf_docl;
    logic [7:0]  rf_dih, rf_dil;
    logic        rf_weh, rf_wel;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] rf [8];
    logic [7:0]  mem [65536];
    bit          mem_vld [65536];
    logic [7:0]  exp_mem [65536];
    int          rf_writes = 0;
    int          mem_writes = 0;

    logic        pl_en = 1'b0;
    logic [15:0] pl_hl, pl_de, pl_bc;
    logic        mpl_en = 1'b0;
    logic [15:0] mpl_addr;
    logic [7:0]  mpl_dat;

    tv80_blkseq dut (
        .clk(clk), .reset(reset), .cen(cen), .start(start),
        .op_dec(op_dec), .op_rpt(op_rpt), .irq_pend(irq_pend),
        .busy(busy), .done(done), .rpt_abort(rpt_abort), .pv_flag(pv_flag),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .mem_ack(mem_ack),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b), .rf_addr_c(rf_addr_c),
        .rf_doah(rf_doah), .rf_doal(rf_doal), .rf_dobh(rf_dobh),
        .rf_dobl(rf_dobl), .rf_doch(rf_doch), .rf_docl(rf_docl),
        .rf_dih(rf_dih), .rf_dil(rf_dil), .rf_weh(rf_weh), .rf_wel(rf_wel)
    );

    assign rf_doah = rf[rf_addr_a][15:8];
    assign rf_doal = rf[rf_addr_a][7:0];
    assign rf_dobh = rf[rf_addr_b][15:8];
    assign rf_dobl = rf[rf_addr_b][7:0];
    assign rf_doch = rf[rf_addr_c][15:8];
    assign rf_docl = rf[rf_addr_c][7:0];
    // Never-written memory reads back an address hash so every byte is defined.
    assign mem_din = mem_vld[mem_addr] ? mem[mem_addr] : (mem_addr[7:0] ^ mem_addr[15:8] ^ 8'h5C);

    always @(posedge clk) begin
        if (pl_en) begin
            rf[2] <= pl_hl;
            rf[1] <= pl_de;
            rf[0] <= pl_bc;
        end else if (cen && rf_weh && rf_wel) begin
            rf[rf_addr_a] <= {rf_dih, rf_dil};
            rf_writes     <= rf_writes + 1;
        end
        if (mpl_en) begin
            mem[mpl_addr]     <= mpl_dat;
            mem_vld[mpl_addr] <= 1'b1;
        end else if (cen && mem_wr && mem_ack) begin
            mem[mem_addr]     <= mem_dout;
            mem_vld[mem_addr] <= 1'b1;
            mem_writes        <= mem_writes + 1;
        end
    end

    function automatic logic [7:0] img(input logic [15:0] a);
        return mem_vld[a] ? mem[a] : (a[7:0] ^ a[15:8] ^ 8'h5C);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] hl, input logic [15:0] de, input logic [15:0] bc);
        pl_hl = hl; pl_de = de; pl_bc = bc; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        mpl_addr = a; mpl_dat = d; mpl_en = 1'b1;
        @(negedge clk);
        mpl_en = 1'b0;
    endtask

    // Reference: copy one byte per iteration, step pointers, count BC down,
    // stop when not repeating, BC reaches 0, or the interrupt was raised in time.
    task automatic model(input logic [15:0] hl_i, input logic [15:0] de_i, input logic [15:0] bc_i,
                         input logic dec, input logic rpt, input int irq_after,
                         output logic [15:0] hl, output logic [15:0] de, output logic [15:0] bc,
                         output int n, output logic abort);
        for (int a = 0; a < 65536; a++) exp_mem[16'(a)] = img(16'(a));
        hl = hl_i; de = de_i; bc = bc_i; n = 0;
        do begin
            exp_mem[de] = exp_mem[hl];
            hl = dec ? hl - 16'd1 : hl + 16'd1;
            de = dec ? de - 16'd1 : de + 16'd1;
            bc = bc - 16'd1;
            n++;
        end while (rpt && bc != 16'd0 && n < irq_after);
        abort = rpt && (bc != 16'd0);
    endtask

    // mode 0: cen high, fixed waits; 1: random cen/ack/start; 2: cen low 4 cycles in UPD_DE
    task automatic do_op(input logic [15:0] hl0, input logic [15:0] de0, input logic [15:0] bc0,
                         input logic dec, input logic rpt, input int irq_after, input int mode,
                         input int fix_rd, input int fix_wr, input int exp_cyc);
        logic [15:0] ehl, ede, ebc;
        logic        eab;
        int          en, rw0, mw0, edges, cycles, waits, wait_left, cur, prev, bad;
        bit          got;
        preload(hl0, de0, bc0);
        model(hl0, de0, bc0, dec, rpt, irq_after, ehl, ede, ebc, en, eab);
        rw0 = rf_writes; mw0 = mem_writes;
        start = 1'b1; op_dec = dec; op_rpt = rpt; cen = 1'b1; irq_pend = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        start = 1'b0; edges = 1; cycles = 1; waits = 0; prev = 0; wait_left = 0; got = 1'b0;
        while (cycles < 2000) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (mode == 1)      cen = ($urandom_range(0, 4) != 0);
            else if (mode == 2) cen = !(cycles >= 4 && cycles < 8);
            else                cen = 1'b1;
            cur = mem_rd ? 1 : (mem_wr ? 2 : 0);
            if (cur != 0 && cur != prev)
                wait_left = (mode == 1) ? int'($urandom_range(0, 2)) : ((cur == 1) ? fix_rd : fix_wr);
            prev = cur;
            if (cur != 0 && cen) begin
                if (wait_left > 0) begin
                    mem_ack = 1'b0; wait_left--; waits++;
                end else begin
                    mem_ack = 1'b1;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            irq_pend = ((mem_writes - mw0) >= irq_after);
            start = (mode == 1) ? 1'($urandom_range(0, 1)) : (cycles == 3);
            if (cen) edges++;
            @(negedge clk);
            cycles++;
        end
        chk("done_seen", 32'(got), 32'd1);
        if (got) begin
            chk("active_edges", edges, 1 + 5 * en + waits);
            if (exp_cyc >= 0) chk("done_cycle", cycles, exp_cyc);
            chk("rpt_abort", 32'(rpt_abort), 32'(eab));
        end
        start = 1'b0; cen = 1'b1; irq_pend = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        if (!got) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
        chk("idle_after", 32'({busy, done}), 32'd0);
        chk("pv_flag", 32'(pv_flag), 32'(ebc != 16'd0));
        chk("hl", 32'(rf[2]), 32'(ehl));
        chk("de", 32'(rf[1]), 32'(ede));
        chk("bc", 32'(rf[0]), 32'(ebc));
        chk("rf_writes", rf_writes - rw0, 3 * en);
        chk("mem_writes", mem_writes - mw0, en);
        bad = 0;
        for (int a = 0; a < 65536; a++) if (img(16'(a)) !== exp_mem[16'(a)]) bad++;
        chk("mem_image", bad, 0);
    endtask

    initial begin
        logic [15:0] r_hl, r_de, r_bc;
        int          r_irq, rw0;
        reset = 1'b1; cen = 1'b0; start = 1'b0; op_dec = 1'b0; op_rpt = 1'b0;
        irq_pend = 1'b0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 32'({busy, done, rpt_abort, pv_flag, mem_rd, mem_wr, rf_weh, rf_wel}), 32'd0);
        chk("reset_data", 32'({mem_dout, rf_dih, rf_dil}), 32'd0);
        chk("reset_addr", 32'({mem_addr, rf_addr_a}), 32'd0);
        chk("addr_b", 32'(rf_addr_b), 32'd2);
        chk("addr_c", 32'(rf_addr_c), 32'd1);
        reset = 1'b0; cen = 1'b1;
        @(negedge clk);

        // LDI
        poke(16'h1000, 8'h5A);
        do_op(16'h1000, 16'h2000, 16'h0003, 1'b0, 1'b0, 1000, 0, 0, 0, 6);
        chk("ldi_byte", 32'(img(16'h2000)), 32'h5A);
        // LDDR wrapping below zero
        do_op(16'h0001, 16'hFFFF, 16'h0002, 1'b1, 1'b1, 1000, 0, 0, 0, 11);
        // LDIR suspended by interrupt after first iteration
        do_op(16'h3000, 16'h4000, 16'h0005, 1'b0, 1'b1, 1, 0, 0, 0, 6);
        // wait states: 3 in RD, 2 in WR, plus an ignored start pulse
        do_op(16'h1000, 16'h2000, 16'h0003, 1'b0, 1'b0, 1000, 0, 3, 2, 11);
        // cen low for 4 cycles in UPD_DE
        do_op(16'h5000, 16'h6000, 16'h0003, 1'b0, 1'b0, 1000, 2, 0, 0, 10);

        // reset in UPD_HL, with cen low on that edge
        preload(16'h1000, 16'h2000, 16'h0003);
        rw0 = rf_writes;
        start = 1'b1; op_dec = 1'b0; op_rpt = 1'b0; cen = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("upd_hl_we", 32'({rf_weh, rf_addr_a}), 32'({1'b1, 3'd2}));
        reset = 1'b1; cen = 1'b0;
        @(negedge clk);
        reset = 1'b0; cen = 1'b1;
        chk("rst_mid_ctl", 32'({busy, done, rpt_abort, pv_flag, mem_rd, mem_wr, rf_weh, rf_wel}), 32'd0);
        chk("rst_mid_data", 32'({mem_dout, rf_dih, rf_dil}), 32'd0);
        chk("rst_mid_addr", 32'({mem_addr, rf_addr_a}), 32'd0);
        chk("rst_mid_hl", 32'(rf[2]), 32'h1000);
        chk("rst_mid_writes", rf_writes - rw0, 0);
        do_op(16'h1000, 16'h2000, 16'h0003, 1'b0, 1'b0, 1000, 0, 0, 0, 6);

        repeat (30) begin
            r_hl  = 16'($urandom);
            r_de  = 16'($urandom);
            r_bc  = 16'($urandom_range(1, 6));
            r_irq = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 1000;
            do_op(r_hl, r_de, r_bc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  r_irq, 1, 0, 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tv80_blkseq.md
# tv80_blkseq

Block-transfer sequencer for the TV80 core: executes LDI, LDD, LDIR and LDDR by driving memory read/write cycles and writing the updated HL, DE and BC pairs back into the 8x16 register file. It sits directly upstream of the register file. It owns that file's write port (address A, DIH/DIL, WEH/WEL) and reads HL, DE and BC through the file's combinational read ports while a block op is active. The core's main sequencer hands control to it on `start` and resumes on `done`.

## Interface

Parameters:
- none

Ports:
- `clk` in 1: core clock
- `reset` in 1: synchronous, active-high
- `cen` in 1: clock enable, the same signal that drives the register file CEN; all state advances only when high
- `start` in 1: begin a block op; sampled in IDLE only
- `op_dec` in 1: 0 = increment HL/DE (LDI/LDIR), 1 = decrement (LDD/LDDR); latched at start
- `op_rpt` in 1: 1 = repeat form (LDIR/LDDR); latched at start
- `irq_pend` in 1: interrupt pending; checked at each repeat decision
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse in DONE
- `rpt_abort` out 1: valid with `done`; 1 = repeat op suspended by an interrupt, so the core must rewind PC by 2
- `pv_flag` out 1: registered (BC after decrement != 0)
- `mem_addr` out 16: HL in RD, DE in WR, else 0
- `mem_rd` out 1: high in RD
- `mem_wr` out 1: high in WR
- `mem_dout` out 8: byte latch, valid in WR
- `mem_din` in 8: read data, captured when `mem_ack` is high in RD
- `mem_ack` in 1: completes the current RD/WR cycle
- `rf_addr_a` out 3: write/read pair; 2 = HL in UPD_HL, 1 = DE in UPD_DE, 0 = BC otherwise
- `rf_addr_b` out 3: constant 2 (HL)
- `rf_addr_c` out 3: constant 1 (DE)
- `rf_doah`, `rf_doal`, `rf_dobh`, `rf_dobl`, `rf_doch`, `rf_docl` in 8 each: register file read data
- `rf_dih`, `rf_dil` out 8: write data
- `rf_weh`, `rf_wel` out 1: high together, in UPD_* states only

## Operation

States: IDLE, RD, WR, UPD_HL, UPD_DE, UPD_BC, DONE. Each transition happens only on an edge where `cen` is high.
- IDLE: on `start`, latch `op_dec` and `op_rpt`, then go to RD.
- RD: `mem_addr` = {dobh,dobl}; `mem_rd` = 1. When `mem_ack` is high, capture `mem_din` into the byte latch and go to WR. Otherwise hold.
- WR: `mem_addr` = {doch,docl}; `mem_wr` = 1; `mem_dout` = latch. When `mem_ack` is high, go to UPD_HL.
- UPD_HL: write {doah,doal} ± 1, then go to UPD_DE.
- UPD_DE: write {doah,doal} ± 1, then go to UPD_BC.
- UPD_BC: write {doah,doal} − 1 and set `pv_flag` = (result != 0). Next state:
  - If `op_rpt` and result != 0 and `irq_pend` is low: go to RD.
  - If `op_rpt` and result != 0 and `irq_pend` is high: go to DONE with `rpt_abort` = 1.
  - Otherwise: go to DONE with `rpt_abort` = 0.
- DONE: `done` = 1, then go to IDLE.

Arithmetic:
- All pair arithmetic is 16-bit modulo 2^16: 0xFFFF+1 = 0x0000 and 0x0000−1 = 0xFFFF.
- BC = 0 at start of a repeat op runs 65536 iterations.

Boundary conditions:
- `start` outside IDLE is ignored.
- `mem_ack` outside RD/WR is ignored.
- `cen` low freezes state, the latch and all registered outputs.
- `reset` in any state returns to IDLE on the next edge regardless of `cen`. No register file write occurs on that edge.

## Timing

Reset values: state IDLE. `busy`, `done`, `rpt_abort`, `pv_flag`, `mem_rd`, `mem_wr`, `rf_weh` and `rf_wel` are 0. `mem_addr` = 0, `mem_dout` = 0, `rf_dih`/`rf_dil` = 0, `rf_addr_a` = 0.

Latency:
- Outputs decode from state, so `mem_*` and `rf_*` are valid in the same cycle the state is entered.
- With `cen` = 1 and `mem_ack` tied high, start in cycle 0 gives: RD in cycle 1, WR 2, UPD_HL 3, UPD_DE 4, UPD_BC 5, DONE 6 (`done` high), IDLE 7.
- Each repeat iteration costs 5 cycles plus memory wait cycles.
- Each cycle that `mem_ack` is low in RD or WR adds one cycle.
- Register writes land on the edge that ends the UPD_* cycle, so the next state reads the updated value.

## Test plan

- LDI: HL=0x1000, DE=0x2000, BC=0x0003, mem[0x1000]=0x5A, ack tied high → write 0x5A @0x2000; HL=0x1001, DE=0x2001, BC=0x0002; `pv_flag`=1; `done` in cycle 6.
- LDDR: HL=0x0001, DE=0xFFFF... no wrap expected beyond modulo; set BC=2 → two transfers from 0x0001/0x0000 to 0xFFFF/0xFFFE; final HL=0xFFFF, DE=0xFFFD, BC=0, `pv_flag`=0, `rpt_abort`=0.
- LDIR with `irq_pend` raised during iteration 1, BC=5 → exits after the first UPD_BC with BC=4, `rpt_abort`=1, `pv_flag`=1.
- Wait states: `mem_ack` low for 3 cycles in RD and 2 in WR → `done` in cycle 11. `start` pulsed mid-op is ignored. `cen` low for 4 cycles in UPD_DE delays `done` by 4 with no extra writes.
- Reset asserted in UPD_HL → IDLE next cycle, all outputs at reset values, HL unchanged. A fresh `start` then behaves as in the first scenario.
